mac_dot_sequencer: RTL and testbench

Sequences the shared combinational MAC datapath (Y = A*B + C) to compute a dot product of length N over a streamed operand sequence. Loads a bias into the accumulator, feeds one operand pair per accepted beat through an internal MAC instance, and feeds Y back as C. Returns the final sum through a valid/ready result port. Sits between an operand-streaming producer and a result consumer in the arithmetic subsystem.

---
 rtl/mac_dot_sequencer.sv | 147 ++++++++++++++
 tb/tb_mac_dot_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_sequencer.sv
// Dot-product sequencer around a combinational MAC (Y = A*B + C).
// The accumulator is loaded with a bias, one operand pair is folded in per
// accepted beat, and the final sum is offered on a valid/ready result port.

module mac_unit #(
    parameter int WIDTH_A = 5,
    parameter int WIDTH_B = 7
) (
    input  logic [WIDTH_A-1:0]         i_a,
    input  logic [WIDTH_B-1:0]         i_b,
    input  logic [WIDTH_A+WIDTH_B-1:0] i_c,
    output logic [WIDTH_A+WIDTH_B-1:0] o_y
);
    localparam int WY = WIDTH_A + WIDTH_B;

    // Product always fits in WY bits; only the add can wrap.
    assign o_y = (WY'(i_a) * WY'(i_b)) + i_c;
endmodule

module mac_dot_sequencer #(
    parameter int WIDTH_A = 5,
    parameter int WIDTH_B = 7,
    parameter int LEN_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [LEN_W-1:0]           len,
    input  logic [WIDTH_A+WIDTH_B-1:0] c_init,
    input  logic                       abort,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH_A-1:0]         in_a,
    input  logic [WIDTH_B-1:0]         in_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH_A+WIDTH_B-1:0] out_y,
    output logic                       out_ovf,
    output logic                       busy
);
    localparam int WY = WIDTH_A + WIDTH_B;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    logic [WY-1:0]    r_acc;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] r_len;
    logic             r_ovf;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WY-1:0]    r_out_y;
    logic             r_out_ovf;
    logic             r_busy;

    logic [WY-1:0]    w_y;
    logic             w_wrap;
    logic             w_last;

    mac_unit #(.WIDTH_A(WIDTH_A), .WIDTH_B(WIDTH_B)) u_mac (
        .i_a (in_a),
        .i_b (in_b),
        .i_c (r_acc),
        .o_y (w_y)
    );

    // A*B < 2^WY, so the sum wrapped exactly when it came out below acc.
    assign w_wrap = (w_y < r_acc);
    assign w_last = (r_cnt == (r_len - LEN_W'(1)));

    // Job FSM; handshake and result outputs are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_len       <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_y     <= '0;
            r_out_ovf   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc  <= c_init;
                        r_ovf  <= 1'b0;
                        r_cnt  <= '0;
                        r_len  <= len;
                        r_busy <= 1'b1;
                        if (len != '0) begin
                            r_state    <= S_RUN;
                            r_in_ready <= 1'b1;
                        end else begin
                            // Empty vector: the bias is the result.
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_out_y     <= c_init;
                            r_out_ovf   <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        // Abort wins over a coincident beat; the beat is dropped.
                        r_state    <= S_IDLE;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                    end else if (in_valid) begin
                        r_acc <= w_y;
                        r_ovf <= r_ovf | w_wrap;
                        r_cnt <= r_cnt + LEN_W'(1);
                        if (w_last) begin
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_out_y     <= w_y;
                            r_out_ovf   <= r_ovf | w_wrap;
                        end
                    end
                end
                S_DONE: begin
                    // Result is held until consumed or the job is cancelled.
                    if (abort || out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_y     = r_out_y;
    assign out_ovf   = r_out_ovf;
    assign busy      = r_busy;
endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Randomized bench for mac_dot_sequencer: each job's result is predicted as
// the exact integer sum of bias and products, reduced modulo 2^12.

module tb_mac_dot_sequencer;
    localparam int WA = 5;
    localparam int WB = 7;
    localparam int LW = 8;
    localparam int WY = WA + WB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic [WY-1:0] c_init = '0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [WA-1:0] in_a = '0;
    logic [WB-1:0] in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [WY-1:0] out_y;
    logic          out_ovf;
    logic          busy;

    int n_chk = 0;
    int n_fail = 0;
    int opa[$];
    int opb[$];

    mac_dot_sequencer #(.WIDTH_A(WA), .WIDTH_B(WB), .LEN_W(LW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .c_init    (c_init),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_ops(input int a0, input int b0, input int cnt);
        opa.delete();
        opb.delete();
        for (int i = 0; i < cnt; i++) begin
            opa.push_back(a0 < 0 ? int'($urandom_range(0, 31)) : a0);
            opb.push_back(b0 < 0 ? int'($urandom_range(0, 127)) : b0);
        end
    endtask

    // Drive one complete job from opa/opb; inputs change on negedge,
    // outputs are sampled on negedge.
    task automatic run_job(input int n, input int ci, input int stall_pct,
                           input int rdy_wait, input bit poke_start);
        longint tot;
        int     idx;
        int     cyc;
        tot = ci;
        for (int i = 0; i < n; i++) tot += longint'(opa[i]) * longint'(opb[i]);

        @(negedge clk);
        start = 1'b1; len = LW'(n); c_init = WY'(ci); in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        idx = 0;
        while (idx < n && cyc < 2000) begin
            chk("in_ready_run", in_ready, 1);
            chk("out_valid_run", out_valid, 0);
            in_valid = ($urandom_range(0, 99) >= stall_pct);
            in_a = WA'(opa[idx]);
            in_b = WB'(opb[idx]);
            if (poke_start) begin
                start = ($urandom_range(0, 2) == 0);
                len = LW'($urandom_range(1, 255));
                c_init = WY'($urandom);
            end
            if (in_valid && in_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        chk("beats_done", idx, n);
        if (stall_pct == 0) chk("latency", cyc, n + 1);
        chk("out_valid", out_valid, 1);
        chk("in_ready_done", in_ready, 0);
        chk("busy_done", busy, 1);
        chk("out_y", out_y, tot % 4096);
        chk("out_ovf", out_ovf, tot >= 4096 ? 1 : 0);
        for (int w = 0; w < rdy_wait; w++) begin
            @(negedge clk);
            chk("out_y_hold", out_y, tot % 4096);
            chk("out_valid_hold", out_valid, 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_fall", out_valid, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_y", out_y, 0);
        chk("rst_out_ovf", out_ovf, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;

        // Basic two-beat job, no stalls.
        opa = '{13, 15}; opb = '{23, 21};
        run_job(2, 1012, 0, 0, 0);

        // Single beat with stalls.
        opa = '{15}; opb = '{21};
        run_job(1, 598, 60, 1, 0);

        // Wrapping accumulation.
        set_ops(31, 127, 3);
        run_job(3, 0, 0, 0, 0);

        // Empty vector, result held under back-pressure.
        opa.delete(); opb.delete();
        run_job(0, 77, 0, 5, 0);

        // Abort mid-job on a coincident beat; first beat wraps to set ovf.
        @(negedge clk);
        start = 1'b1; len = 4; c_init = 4000;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_a = 31; in_b = 127;
            @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        for (int k = 0; k < 4; k++) begin
            chk("abort_no_result", out_valid, 0);
            @(negedge clk);
        end
        opa = '{2}; opb = '{3};
        run_job(1, 5, 0, 0, 0);

        // Start poked during RUN must not change the job.
        set_ops(-1, -1, 6);
        run_job(6, 100, 20, 0, 1);

        // Reset while a result is pending.
        opa.delete(); opb.delete();
        @(negedge clk);
        start = 1'b1; len = 0; c_init = 9;
        @(negedge clk);
        start = 1'b0;
        chk("pre_rst_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_out_y", out_y, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random jobs.
        for (int j = 0; j < 25; j++) begin
            int n;
            n = $urandom_range(0, 12);
            set_ops(-1, -1, n);
            run_job(n, int'($urandom_range(0, 4095)), int'($urandom_range(0, 40)),
                    int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
